// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: one outstanding access over valid/ready handshakes,
// with lane alignment, byte strobes, load extension and local trapping of bad accesses.
module lsu_mem_port #(
    parameter int XLEN = 64,
    parameter int AW   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_addr,
    input  logic [XLEN-1:0]        in_wdata,
    input  logic [3:0]             in_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_rdata,
    output logic                   out_err,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_we,
    output logic [AW-1:0]          mem_req_addr,
    output logic [XLEN-1:0]        mem_req_wdata,
    output logic [XLEN/8-1:0]      mem_req_wstrb,
    input  logic                   mem_resp_valid,
    input  logic [XLEN-1:0]        mem_resp_rdata,
    input  logic                   mem_resp_err
);

    localparam int LANES = XLEN / 8;
    localparam int OFFW  = $clog2(LANES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                 state_r;
    logic [XLEN-1:0]        out_rdata_r;
    logic                   out_err_r;
    logic                   mem_req_we_r;
    logic [AW-1:0]          mem_req_addr_r;
    logic [XLEN-1:0]        mem_req_wdata_r;
    logic [LANES-1:0]       mem_req_wstrb_r;
    logic [OFFW-1:0]        off_r;
    logic [3:0]             size_r;
    logic                   sign_r;
    logic                   store_r;

    logic                   legal_s;
    logic                   store_s;
    logic                   sign_s;
    logic [3:0]             size_s;
    logic [OFFW-1:0]        off_s;
    logic [3:0]             off_ext_s;
    logic                   misalign_s;
    logic [XLEN-1:0]        st_wdata_s;
    logic [LANES-1:0]       st_wstrb_s;

    // Shift the aligned word down to the accessed lane, keep size bytes, then extend.
    function automatic logic [XLEN-1:0] fmt_load(
        input logic [XLEN-1:0] word,
        input logic [OFFW-1:0] off,
        input logic [3:0]      size,
        input logic            sgn
    );
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] keep;
        logic            ext;
        shifted = word >> {off, 3'b000};
        keep    = '0;
        ext     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(size)) begin
                keep[8*i +: 8] = 8'hFF;
            end
            if (i == int'(size) - 1) begin
                ext = shifted[8*i+7];
            end
        end
        return (sgn && ext) ? (shifted | ~keep) : (shifted & keep);
    endfunction

    function automatic logic [LANES-1:0] lane_strb(
        input logic [OFFW-1:0] off,
        input logic [3:0]      size
    );
        logic [LANES-1:0] strb;
        strb = '0;
        for (int i = 0; i < LANES; i++) begin
            strb[i] = (i >= int'(off)) && (i < int'(off) + int'(size));
        end
        return strb;
    endfunction

    // Operation decode; 8-byte accesses only exist on a 64-bit datapath.
    always_comb begin
        legal_s = 1'b1;
        store_s = 1'b0;
        sign_s  = 1'b0;
        size_s  = 4'd1;
        case (in_ctrl)
            4'b0000: begin size_s = 4'd8; legal_s = (XLEN == 64); end
            4'b0001: begin size_s = 4'd2; end
            4'b0010: begin size_s = 4'd1; end
            4'b0011: begin size_s = 4'd4; sign_s = 1'b1; end
            4'b0100: begin size_s = 4'd2; sign_s = 1'b1; end
            4'b0101: begin size_s = 4'd4; end
            4'b0110: begin size_s = 4'd1; sign_s = 1'b1; end
            4'b1000: begin size_s = 4'd8; store_s = 1'b1; legal_s = (XLEN == 64); end
            4'b1001: begin size_s = 4'd4; store_s = 1'b1; end
            4'b1010: begin size_s = 4'd2; store_s = 1'b1; end
            4'b1011: begin size_s = 4'd1; store_s = 1'b1; end
            default: begin legal_s = 1'b0; end
        endcase
    end

    assign off_s      = in_addr[OFFW-1:0];
    assign off_ext_s  = {{(4-OFFW){1'b0}}, off_s};
    assign misalign_s = |(off_ext_s & (size_s - 4'd1));
    assign st_wdata_s = in_wdata << {off_s, 3'b000};
    assign st_wstrb_s = lane_strb(off_s, size_s);

    // Access sequencer; all result and bus fields are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            out_rdata_r     <= '0;
            out_err_r       <= 1'b0;
            mem_req_we_r    <= 1'b0;
            mem_req_addr_r  <= '0;
            mem_req_wdata_r <= '0;
            mem_req_wstrb_r <= '0;
            off_r           <= '0;
            size_r          <= 4'd0;
            sign_r          <= 1'b0;
            store_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        out_rdata_r <= '0;
                        off_r       <= off_s;
                        size_r      <= size_s;
                        sign_r      <= sign_s;
                        store_r     <= store_s;
                        if (!legal_s || misalign_s) begin
                            out_err_r <= 1'b1;
                            state_r   <= ST_RESP;
                        end else begin
                            out_err_r       <= 1'b0;
                            mem_req_we_r    <= store_s;
                            mem_req_addr_r  <= {in_addr[AW-1:OFFW], {OFFW{1'b0}}};
                            mem_req_wdata_r <= store_s ? st_wdata_s : '0;
                            mem_req_wstrb_r <= store_s ? st_wstrb_s : '0;
                            state_r         <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        out_err_r   <= mem_resp_err;
                        out_rdata_r <= (store_r || mem_resp_err) ? '0
                                     : fmt_load(mem_resp_rdata, off_r, size_r, sign_r);
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = (state_r == ST_IDLE);
    assign out_valid     = (state_r == ST_RESP);
    assign mem_req_valid = (state_r == ST_REQ);
    assign out_rdata     = out_rdata_r;
    assign out_err       = out_err_r;
    assign mem_req_we    = mem_req_we_r;
    assign mem_req_addr  = mem_req_addr_r;
    assign mem_req_wdata = mem_req_wdata_r;
    assign mem_req_wstrb = mem_req_wstrb_r;

endmodule
